accum_rr_scheduler: RTL and testbench
=====================================

// Module: accum_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one WIDTH-bit wrap-around accumulator between
//  NREQ requesters. Each requester posts an increment step. The block arbitrates,
//  applies the winner's step to the shared accumulator, and returns a one-cycle
//  grant. It sits in front of the step-counter datapath and owns the only write
//  port of the running total.
// PARAMETERS
//  NREQ       4   number of requesters (2..16)
//  WIDTH      32  accumulator and step width in bits
//  EVEN_ONLY  1   1: odd steps are rejected with err; 0: any step is accepted
// PORTS
//  CLK    in   1           clock, rising edge
//  RST_N  in   1           asynchronous active-low reset
//  clr    in   1           synchronous clear of acc/ovf; priority over operations
//  req    in   NREQ        per-requester request level
//  step   in   NREQ*WIDTH  per-requester step; requester i uses bits [i*WIDTH +: WIDTH]
//  gnt    out  NREQ        one-hot, one-cycle completion pulse
//  err    out  1           pulses with gnt when the step was rejected (odd, EVEN_ONLY=1)
//  acc    out  WIDTH       shared accumulator value
//  ovf    out  1           sticky; set on carry out of bit WIDTH-1
//  busy   out  1           1 while in APPLY
//  owner  out  clog2(NREQ) index of the requester currently or last served
// BEHAVIOUR
//  - Reset (RST_N=0, async): all outputs 0, rr pointer=0, state=IDLE.
//  - FSM has two states: IDLE and APPLY.
//  - IDLE: if clr, then acc=0 and ovf=0; no arbitration takes place that cycle.
//    Otherwise, if any req is set, pick a winner, latch its step into step_q,
//    set owner=winner, busy=1, and go to APPLY.
//  - Arbitration: search starts at the rr pointer and wraps modulo NREQ; the
//    first set req wins.
//  - APPLY (one cycle):
//    - If clr: acc=0, ovf=0, no gnt, rr pointer unchanged, go to IDLE. The
//      requester stays pending and is re-arbitrated.
//    - Otherwise: gnt[owner]=1 for this cycle only and the rr pointer becomes
//      owner+1 mod NREQ.
//    - If EVEN_ONLY and step_q[0]==1: err=1 and acc is unchanged.
//    - Otherwise: acc=(acc+step_q) mod 2^WIDTH; ovf|=carry.
//    - busy drops and the FSM returns to IDLE.
//  - Latency: a request seen in IDLE at edge N gets its gnt and new acc after
//    edge N+1. Maximum throughput is one operation per 2 cycles.
//  - gnt and err are 0 outside APPLY; at most one gnt bit is ever set.
//  - Requester protocol:
//    - Hold req and step stable until gnt; drop req in the gnt cycle unless
//      another operation is wanted.
//    - Dropping req during APPLY does not cancel the operation; the latched
//      step still applies.
//  - owner holds its value after completion until the next arbitration.
//  - ovf is cleared only by clr or reset. A wrap to exactly 0 with a carry
//    sets ovf.
//  - Reset during APPLY: the operation is abandoned at once with no gnt, and
//    acc and ovf are 0.
// TESTING
//  1. Reset, then req[0]=1 with step0=2 -> gnt[0] one cycle after the grant
//     decision; acc=2, err=0, ovf=0.
//  2. req=4'b1111 held with steps 2,4,6,8 -> gnt order 0,1,2,3,0, one gnt every
//     2 cycles; acc=20 after the first 4 gnts.
//  3. WIDTH=8, acc driven to 0xFE, then step 4 -> acc=0x02, ovf=1; a following
//     step 2 leaves ovf=1.
//  4. EVEN_ONLY=1, req[2] with step 3 -> gnt[2]=1, err=1, acc unchanged; the
//     next grant goes to req3 if it is pending.
//  5. clr in the APPLY cycle of req[1] -> no gnt, acc=0, ovf=0; req[1] still
//     high is granted within 2 cycles.
//  6. RST_N low in the middle of APPLY -> gnt, acc, busy, owner and ovf go to 0
//     immediately without a clock edge; normal operation resumes after release.

Source files
------------

// File: rtl/accum_rr_scheduler.sv
// Round-robin arbiter in front of a shared wrap-around accumulator.
// One requester is served per two cycles; the grant is a completion pulse.
module accum_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int EVEN_ONLY = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    step,
  output logic [NREQ-1:0]          gnt,
  output logic                     err,
  output logic [WIDTH-1:0]         acc,
  output logic                     ovf,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE,
    S_APPLY
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [OW-1:0]     r_ptr;
  logic [OW-1:0]     r_owner;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_step_q;
  logic              r_ovf;
  logic [NREQ-1:0]   r_gnt;
  logic              r_err;

  logic              w_any;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_ptr_nx;
  logic [WIDTH-1:0]  w_step_sel;
  logic [WIDTH:0]    w_sum;
  logic              w_odd;

  // Rotating search: first set request at or after the pointer.
  always_comb begin
    logic [OW:0] idx;
    w_any = 1'b0;
    w_win = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NREQ)) begin
        idx = idx - (OW+1)'(NREQ);
      end
      if (!w_any && req[idx[OW-1:0]]) begin
        w_any = 1'b1;
        w_win = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    logic [OW:0] nx;
    nx = {1'b0, r_owner} + (OW+1)'(1);
    if (nx >= (OW+1)'(NREQ)) begin
      nx = '0;
    end
    w_ptr_nx = nx[OW-1:0];
  end

  assign w_step_sel = step[int'(w_win)*WIDTH +: WIDTH];
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_step_q};
  assign w_odd      = (EVEN_ONLY != 0) && r_step_q[0];

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!clr && w_any) begin
          w_state_nx = S_APPLY;
        end
      end
      S_APPLY: begin
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_acc    <= '0;
      r_step_q <= '0;
      r_ovf    <= 1'b0;
      r_gnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_gnt <= '0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (w_any) begin
            r_step_q <= w_step_sel;
            r_owner  <= w_win;
          end
        end
        S_APPLY: begin
          // A clear here drops the operation; the requester stays pending.
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else begin
            r_gnt <= NREQ'(1) << r_owner;
            r_ptr <= w_ptr_nx;
            if (w_odd) begin
              r_err <= 1'b1;
            end else begin
              r_acc <= w_sum[WIDTH-1:0];
              r_ovf <= r_ovf | w_sum[WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign err   = r_err;
  assign acc   = r_acc;
  assign ovf   = r_ovf;
  assign busy  = (r_state == S_APPLY);
  assign owner = r_owner;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// Bench for accum_rr_scheduler: directed scenarios then random traffic
// against an arithmetic model of the round-robin accumulator.
module tb_accum_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              clr = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*WIDTH-1:0] step = '0;
  logic [NREQ-1:0]   gnt;
  logic              err;
  logic [WIDTH-1:0]  acc;
  logic              ovf;
  logic              busy;
  logic [1:0]        owner;

  int checks = 0;
  int failures = 0;

  int m_acc = 0;
  bit m_ovf = 0;
  int m_ptr = 0;

  accum_rr_scheduler #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .EVEN_ONLY(1)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .clr(clr),
    .req(req),
    .step(step),
    .gnt(gnt),
    .err(err),
    .acc(acc),
    .ovf(ovf),
    .busy(busy),
    .owner(owner)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    clr = 1'b0;
    req = '0;
    step = '0;
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    m_acc = 0;
    m_ovf = 0;
    m_ptr = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Called with the DUT idle and req/step already driven.
  task automatic run_op(string tag);
    int w;
    int n;
    int s;
    bit e_err;
    w = pick(req);
    s = int'(step[w*WIDTH +: WIDTH]);
    e_err = s[0];
    if (!e_err) begin
      m_acc = m_acc + s;
      if (m_acc >= 256) begin
        m_ovf = 1;
        m_acc = m_acc - 256;
      end
    end
    m_ptr = (w + 1) % NREQ;
    n = 0;
    while (n < 8) begin
      @(posedge CLK);
      #1;
      n++;
      if (gnt != '0) break;
    end
    chk({tag, "_lat"}, 32'(n), 2);
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_owner"}, 32'(owner), 32'(w));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    do_reset();

    req = 4'b0001;
    step[0 +: 8] = 8'd2;
    run_op("t1");
    req = '0;

    do_reset();
    req = 4'b1111;
    step = {8'd8, 8'd6, 8'd4, 8'd2};
    for (int i = 0; i < 5; i++) begin
      run_op("t2");
      if (i == 3) chk("t2_acc20", 32'(acc), 20);
    end
    req = '0;

    do_reset();
    req = 4'b0001;
    step[0 +: 8] = 8'h7E;
    run_op("t3a");
    step[0 +: 8] = 8'h80;
    run_op("t3b");
    chk("t3_fe", 32'(acc), 32'hFE);
    step[0 +: 8] = 8'h04;
    run_op("t3c");
    chk("t3_wrap", 32'(acc), 32'h02);
    step[0 +: 8] = 8'h02;
    run_op("t3d");
    chk("t3_sticky", 32'(ovf), 1);
    req = '0;

    do_reset();
    req = 4'b1100;
    step = {8'd6, 8'd3, 8'd0, 8'd0};
    run_op("t4a");
    req = 4'b1000;
    run_op("t4b");
    req = '0;

    do_reset();
    req = 4'b0001;
    step = {8'd0, 8'd0, 8'd4, 8'd2};
    run_op("t5a");
    req = 4'b0010;
    @(posedge CLK);
    #1;
    chk("t5_busy", 32'(busy), 1);
    clr = 1'b1;
    @(posedge CLK);
    #1;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_acc", 32'(acc), 0);
    chk("t5_ovf", 32'(ovf), 0);
    chk("t5_idle", 32'(busy), 0);
    clr = 1'b0;
    m_acc = 0;
    m_ovf = 0;
    run_op("t5b");
    req = '0;

    do_reset();
    req = 4'b0001;
    step = {8'd0, 8'd6, 8'd0, 8'h80};
    run_op("t6a");
    run_op("t6b");
    chk("t6_ovf", 32'(ovf), 1);
    req = 4'b0100;
    @(posedge CLK);
    #1;
    chk("t6_busy", 32'(busy), 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_acc", 32'(acc), 0);
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_owner", 32'(owner), 0);
    chk("t6_ovf0", 32'(ovf), 0);
    m_acc = 0;
    m_ovf = 0;
    m_ptr = 0;
    #2;
    RST_N = 1'b1;
    run_op("t6c");
    req = '0;

    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        req = '0;
        clr = 1'b1;
        @(posedge CLK);
        #1;
        clr = 1'b0;
        m_acc = 0;
        m_ovf = 0;
        chk("rnd_clr", 32'(acc), 0);
      end
      req = NREQ'($urandom_range(1, 15));
      step = $urandom;
      run_op("rnd");
    end
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
